// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides and
// registered carry/zero/overflow/negative flags.
// S1 captures operands (and runs the shift-add multiplier); S2 holds the
// result and flags presented downstream.
// Optional feature macro: ALU_MUL_EN -- when defined, opcode 111 is a
// D_WIDTH-iteration shift-add multiply; otherwise it is a single-cycle op
// returning 0 with zero=1.
module alu_pipe #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] opA,
  input  logic [D_WIDTH-1:0] opB,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               overflow,
  output logic               negative
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [D_WIDTH:0]          SH_LIM = (D_WIDTH+1)'(D_WIDTH);
  localparam logic signed [D_WIDTH-1:0] S_ZERO = '0;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(D_WIDTH + 1);
  typedef enum logic [1:0] {EMPTY, HOLD, MUL_BUSY, MUL_DONE} s1_state_t;
`else
  typedef enum logic [1:0] {EMPTY, HOLD} s1_state_t;
`endif

  typedef struct packed {
    logic [D_WIDTH-1:0] res;
    logic               c;
    logic               ov;
  } alu_res_t;

  // Single-cycle opcodes; MUL is resolved from the S1 accumulator instead.
  function automatic alu_res_t alu_eval(input logic [2:0] op,
                                        input logic [D_WIDTH-1:0] a,
                                        input logic [D_WIDTH-1:0] b);
    alu_res_t                  r;
    logic [D_WIDTH:0]          u_sum;
    logic signed [D_WIDTH-1:0] sa, sb, sr;
    r     = '0;
    u_sum = '0;
    sa    = $signed(a);
    sb    = $signed(b);
    sr    = S_ZERO;
    case (op)
      OP_ADD: begin
        u_sum = {1'b0, a} + {1'b0, b};
        sr    = sa + sb;
        r.res = u_sum[D_WIDTH-1:0];
        r.c   = u_sum[D_WIDTH];
        r.ov  = ((sa < S_ZERO) == (sb < S_ZERO)) && ((sr < S_ZERO) != (sa < S_ZERO));
      end
      OP_SUB: begin
        u_sum = {1'b0, a} - {1'b0, b};
        sr    = sa - sb;
        r.res = u_sum[D_WIDTH-1:0];
        r.c   = u_sum[D_WIDTH];
        r.ov  = ((sa < S_ZERO) != (sb < S_ZERO)) && ((sr < S_ZERO) != (sa < S_ZERO));
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_SHL: r.res = ({1'b0, b} >= SH_LIM) ? '0 : (a << b);
      OP_SHR: r.res = ({1'b0, b} >= SH_LIM) ? '0 : (a >> b);
      default: r = '0;
    endcase
    return r;
  endfunction

  s1_state_t          state_q, state_d;
  logic [D_WIDTH-1:0] opa_p1_q, opa_p1_d;
  logic [D_WIDTH-1:0] opb_p1_q, opb_p1_d;
  logic [2:0]         opc_p1_q, opc_p1_d;
`ifdef ALU_MUL_EN
  logic [D_WIDTH-1:0] mhi_p1_q, mhi_p1_d;
  logic [CNT_W-1:0]   cnt_p1_q, cnt_p1_d;
  logic [D_WIDTH:0]   mul_sum;
`endif

  logic               vld_p2_q, vld_p2_d;
  logic [D_WIDTH-1:0] res_p2_q, res_p2_d;
  logic               cry_p2_q, cry_p2_d;
  logic               zro_p2_q, zro_p2_d;
  logic               ovf_p2_q, ovf_p2_d;
  logic               neg_p2_q, neg_p2_d;

  logic     s1_full, s1_adv, in_xfer, out_xfer;
  alu_res_t ev;

`ifdef ALU_MUL_EN
  assign s1_full = (state_q == HOLD) || (state_q == MUL_DONE);
`else
  assign s1_full = (state_q == HOLD);
`endif
  assign s1_adv   = s1_full && (!vld_p2_q || out_ready);
  assign in_ready = (state_q == EMPTY) || s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p2_q && out_ready;

  // S1 next state: capture on transfer, release on advance, iterate the multiplier.
  always_comb begin
    state_d  = state_q;
    opa_p1_d = opa_p1_q;
    opb_p1_d = opb_p1_q;
    opc_p1_d = opc_p1_q;
`ifdef ALU_MUL_EN
    mhi_p1_d = mhi_p1_q;
    cnt_p1_d = cnt_p1_q;
    mul_sum  = '0;
`endif
    if (s1_adv) state_d = EMPTY;
`ifdef ALU_MUL_EN
    if (state_q == MUL_BUSY) begin
      // Add multiplicand into the high half when the multiplier LSB is set,
      // then shift the {high, low} pair right by one.
      mul_sum  = {1'b0, mhi_p1_q} + (opb_p1_q[0] ? {1'b0, opa_p1_q} : '0);
      mhi_p1_d = mul_sum[D_WIDTH:1];
      opb_p1_d = {mul_sum[0], opb_p1_q[D_WIDTH-1:1]};
      cnt_p1_d = cnt_p1_q - CNT_W'(1);
      if (cnt_p1_q == CNT_W'(1)) state_d = MUL_DONE;
    end
`endif
    if (in_xfer) begin
      opa_p1_d = opA;
      opb_p1_d = opB;
      opc_p1_d = opcode;
      state_d  = HOLD;
`ifdef ALU_MUL_EN
      if (opcode == OP_MUL) begin
        state_d  = MUL_BUSY;
        mhi_p1_d = '0;
        cnt_p1_d = CNT_W'(D_WIDTH);
      end
`endif
    end
  end

  // S1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      opa_p1_q <= '0;
      opb_p1_q <= '0;
      opc_p1_q <= '0;
`ifdef ALU_MUL_EN
      mhi_p1_q <= '0;
      cnt_p1_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opa_p1_q <= opa_p1_d;
      opb_p1_q <= opb_p1_d;
      opc_p1_q <= opc_p1_d;
`ifdef ALU_MUL_EN
      mhi_p1_q <= mhi_p1_d;
      cnt_p1_q <= cnt_p1_d;
`endif
    end
  end

  // S1 -> S2 boundary: evaluate the op and load result/flags when S1 advances.
  always_comb begin
    ev = alu_eval(opc_p1_q, opa_p1_q, opb_p1_q);
`ifdef ALU_MUL_EN
    if (opc_p1_q == OP_MUL) begin
      ev.res = opb_p1_q;
      ev.c   = |mhi_p1_q;
      ev.ov  = 1'b0;
    end
`endif
    vld_p2_d = vld_p2_q;
    res_p2_d = res_p2_q;
    cry_p2_d = cry_p2_q;
    zro_p2_d = zro_p2_q;
    ovf_p2_d = ovf_p2_q;
    neg_p2_d = neg_p2_q;
    if (out_xfer) vld_p2_d = 1'b0;
    if (s1_adv) begin
      vld_p2_d = 1'b1;
      res_p2_d = ev.res;
      cry_p2_d = ev.c;
      zro_p2_d = (ev.res == '0);
      ovf_p2_d = ev.ov;
      neg_p2_d = ev.res[D_WIDTH-1];
    end
  end

  // S2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      cry_p2_q <= 1'b0;
      zro_p2_q <= 1'b0;
      ovf_p2_q <= 1'b0;
      neg_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
      cry_p2_q <= cry_p2_d;
      zro_p2_q <= zro_p2_d;
      ovf_p2_q <= ovf_p2_d;
      neg_p2_q <= neg_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = res_p2_q;
  assign carry     = cry_p2_q;
  assign zero      = zro_p2_q;
  assign overflow  = ovf_p2_q;
  assign negative  = neg_p2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a
// behavioural reference model and a transfer-ordered scoreboard.
module tb_alu_pipe;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         negative;

  int n_vec;
  int n_err;

  logic [W+3:0] sbq[$];
  logic         hold_pending;
  logic [W+3:0] held;

  alu_pipe #(.D_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  // Reference: {result, carry, zero, overflow, negative} from the ALU rules.
  function automatic logic [W+3:0] model(input int a, input int b, input int op);
    int r, c, o, s, sa, sb;
    r = 0; c = 0; o = 0; s = 0;
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    case (op)
      0: begin r = (a + b) % M; c = (a + b) / M; s = sa + sb; o = int'(s >= M/2 || s < -M/2); end
      1: begin r = (a - b + M) % M; c = int'(a < b); s = sa - sb; o = int'(s >= M/2 || s < -M/2); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= W) ? 0 : (a << b) % M;
      6: r = (b >= W) ? 0 : (a >> b);
`ifdef ALU_MUL_EN
      7: begin r = (a * b) % M; c = int'(a * b >= M); end
`else
      7: r = 0;
`endif
      default: r = 0;
    endcase
    return {r[W-1:0], c[0], (r == 0), o[0], r[W-1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update scoreboard, advance.
  task automatic cycle();
    logic [W+3:0] obs;
    #1;
    obs = {result, carry, zero, overflow, negative};
    if (hold_pending) chk("hold_stable", {out_valid, obs}, {1'b1, held});
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("out_unexpected", out_valid, 1'b0);
      else chk("sb_out", obs, sbq.pop_front());
    end
    hold_pending = out_valid && !out_ready;
    held = obs;
    if (in_valid && in_ready) sbq.push_back(model(opA, opB, opcode));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input int exp_lat, input logic [W+3:0] exp, input bit busy,
                          input string tag);
    int lat;
    opA = a; opB = b; opcode = op; in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (busy && lat <= W) begin
        #1;
        chk({tag, "_busy_rdy"}, in_ready, 0);
      end
      cycle();
      lat++;
    end
    #1;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_val"}, {result, carry, zero, overflow, negative}, exp);
    cycle();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {out_valid, result, carry, zero, overflow, negative}, 0);
    sbq.delete();
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int guard;
    n_vec = 0; n_err = 0;
    clk = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opA = '0; opB = '0; opcode = '0;
    hold_pending = 1'b0; held = '0;

    do_reset();
    chk("reset_state", {out_valid, result, carry, zero, overflow, negative}, 0);

    // Directed arithmetic cases.
    directed(8'hAA, 8'hBB, 3'b000, 2, {8'h65, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b0, "add_aa_bb");
    directed(8'hAA, 8'hBB, 3'b001, 2, {8'hEF, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b0, "sub_aa_bb");
    directed(8'h80, 8'h80, 3'b000, 2, {8'h00, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b0, "add_80_80");
    directed(8'h01, 8'h09, 3'b101, 2, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0, "shl_over");
    directed(8'h80, 8'h07, 3'b110, 2, {8'h01, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, "shr_80_7");
    directed(8'h7F, 8'h01, 3'b000, 2, {8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b0, "add_pos_ovf");
`ifdef ALU_MUL_EN
    directed(8'h0F, 8'h11, 3'b111, W + 2, {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1, "mul_0f_11");
    directed(8'h10, 8'h10, 3'b111, W + 2, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b1, "mul_10_10");
`else
    directed(8'h0F, 8'h11, 3'b111, 2, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0, "op7_legacy");
`endif

    // Incrementing stream of 20 ops.
    for (int i = 0; i < 20; i++) begin
      opA = 8'hAA + W'(i); opB = 8'hBB + W'(i); opcode = 3'(i); in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin cycle(); guard++; end
      cycle();
    end
    in_valid = 1'b0;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin cycle(); guard++; end
    chk("inc_drain", sbq.size(), 0);

    // Back-to-back non-MUL ops must be accepted every cycle.
    for (int i = 0; i < 20; i++) begin
      opA = W'($urandom); opB = W'($urandom_range(0, 10)); opcode = 3'($urandom_range(0, 6));
      in_valid = 1'b1;
      #1;
      chk("tput_rdy", in_ready, 1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("tput_drain", sbq.size(), 0);

    // Backpressure: S1 and S2 fill, in_ready drops, outputs hold.
    out_ready = 1'b0;
    opA = 8'h11; opB = 8'h22; opcode = 3'b000; in_valid = 1'b1;
    cycle();
    opA = 8'h33; opB = 8'h44; opcode = 3'b100;
    cycle();
    opA = 8'h55; opB = 8'h66; opcode = 3'b001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("bp_drain", sbq.size(), 0);

    // Random traffic with random backpressure, all opcodes.
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      opA = W'($urandom);
      opB = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 12));
      opcode = 3'($urandom_range(0, 7));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (sbq.size() != 0 && guard < 100) begin cycle(); guard++; end
    chk("rand_drain", sbq.size(), 0);

    // Reset in the middle of an operation discards it.
    out_ready = 1'b0;
`ifdef ALU_MUL_EN
    opA = 8'hFF; opB = 8'hFF; opcode = 3'b111;
`else
    opA = 8'hFF; opB = 8'hFF; opcode = 3'b000;
`endif
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    do_reset();
    out_ready = 1'b1;
    directed(8'h01, 8'h01, 3'b000, 2, {8'h02, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, "post_rst_add");
    repeat (2) cycle();
    chk("final_drain", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
